hazard_stall_unit: RTL and testbench
====================================

Name: hazard_stall_unit

Overview:
- Producer side of the EX-stage operand-forwarding interface.
- Tracks the destination tag (rd, RegWrite, MemRead) of every in-flight instruction through the ID/EX, EX/MEM and MEM/WB pipeline registers.
- Drives the rd/RegWrite signals for EX/MEM and MEM/WB that the forwarding logic consumes.
- Detects hazards forwarding cannot cover (load-use, multi-cycle multiply) and branch-taken flushes, and generates the stall, bubble and flush controls for the front end.

Parameters:
- REG_ADDR_W, 5, register-index width.
- MUL_LATENCY, 4, total EX cycles a multiply occupies; legal values are 2 to 15.

Ports:
- clk, input, 1, pipeline clock.
- rst, input, 1, asynchronous active-high reset.
- id_valid, input, 1, IF/ID holds a real instruction.
- rs1_IF_ID, input, REG_ADDR_W, source register 1 of the instruction in ID.
- rs2_IF_ID, input, REG_ADDR_W, source register 2 of the instruction in ID.
- id_uses_rs2, input, 1, the instruction in ID reads rs2.
- id_rd, input, REG_ADDR_W, destination register of the instruction in ID.
- id_RegWrite, input, 1, the instruction in ID writes a register.
- id_MemRead, input, 1, the instruction in ID is a load.
- id_is_mul, input, 1, the instruction in ID is a multiply.
- branch_taken_EX, input, 1, a branch resolved taken in EX this cycle.
- PCWrite, output, 1, PC update enable.
- IF_ID_Write, output, 1, IF/ID register load enable.
- bubble_ID_EX, output, 1, load a NOP into ID/EX.
- flush_IF_ID, output, 1, clear IF/ID.
- ex_busy, output, 1, a multiply is occupying EX.
- rd_EX_MEM, output, REG_ADDR_W, forwarding interface: EX/MEM destination register.
- RegWrite_EX_MEM, output, 1, forwarding interface: EX/MEM register-write enable.
- rd_MEM_WB, output, REG_ADDR_W, forwarding interface: MEM/WB destination register.
- RegWrite_MEM_WB, output, 1, forwarding interface: MEM/WB register-write enable.

Behaviour:
- Reset: one clock, clk; reset rst is asynchronous and active-high.
  - All three tags are invalid, state is IDLE, mul_cnt is 0.
  - PCWrite = 1, IF_ID_Write = 1, bubble_ID_EX = 0, flush_IF_ID = 0, ex_busy = 0.
  - All forwarding outputs are 0.
  - Reset asserted mid-stall or mid-multiply aborts immediately to these values.
- Tag pipeline: tag = {valid, rd, regwrite, memread}, held in three registers: EX, MEM, WB.
  - Each cycle the MEM tag moves to WB.
  - The EX tag moves to MEM unless ex_busy; while busy, MEM receives an invalid tag.
  - The ID fields load into EX when ID advances. ID advances when not stalled, not flushed and not busy.
  - A bubble loads an invalid tag into EX.
- Forwarding outputs, all registered (no combinational path from the ID inputs):
  - RegWrite_EX_MEM = MEM.valid & MEM.regwrite.
  - rd_EX_MEM = MEM.rd when MEM is valid, else 0.
  - The MEM_WB outputs are derived the same way from the WB tag.
- Load-use detection (combinational), asserted when all of the following hold:
  - id_valid;
  - EX.valid & EX.memread & EX.regwrite;
  - EX.rd != 0;
  - EX.rd == rs1_IF_ID, or (id_uses_rs2 & EX.rd == rs2_IF_ID).
  - Response: PCWrite = 0, IF_ID_Write = 0, bubble_ID_EX = 1, for exactly 1 cycle. The load then moves to MEM and the condition clears.
- FSM with states IDLE and MUL_BUSY:
  - IDLE -> MUL_BUSY when a multiply advances from ID into EX; mul_cnt is loaded with MUL_LATENCY-1.
  - In MUL_BUSY:
    - ex_busy = 1, PCWrite = 0, IF_ID_Write = 0, bubble_ID_EX = 0.
    - The EX tag is held; mul_cnt decrements each cycle.
    - Exit to IDLE when mul_cnt reaches 1 and decrements to 0.
    - The multiply tag leaves EX on the first cycle after busy ends.
  - ex_busy is registered: it rises the cycle after the multiply enters EX.
- Branch flush, when branch_taken_EX = 1 in IDLE:
  - flush_IF_ID = 1, bubble_ID_EX = 1, PCWrite = 1, IF_ID_Write = 1.
  - Flush has priority over load-use stall; a multiply in ID during a flush does not start the FSM.
- branch_taken_EX is ignored in MUL_BUSY.
- A load-use hazard and MUL_BUSY cannot coincide because busy stalls ID; if both evaluate true, busy outputs win.

Decomposition:
- Shared pipeline package:
  - REG_ADDR_W;
  - the tag struct {valid, rd, regwrite, memread};
  - FSM state encoding (IDLE = 0, MUL_BUSY = 1);
  - the constant ZERO_REG = 0.
- One natural sub-module, hazard_tag_stage: a single tag register with load, hold and bubble inputs, instantiated three times.
- The FSM and hazard comparators stay in the top module.

Test Plan:
- Reset mid-multiply: assert rst during MUL_BUSY with mul_cnt = 2 -> same cycle, ex_busy = 0, PCWrite = 1, all forwarding outputs 0; after release the FSM is IDLE.
- Load-use: load writing r5 in EX, ID reads rs1 = 5 -> for exactly 1 cycle PCWrite = 0, IF_ID_Write = 0, bubble_ID_EX = 1. Next cycle no stall, rd_EX_MEM = 5, RegWrite_EX_MEM = 1; one cycle later rd_MEM_WB = 5.
- No false stall:
  - load writing r0, ID reads rs1 = 0 -> no stall;
  - load writing r7, ID reads rs2 = 7 with id_uses_rs2 = 0 -> no stall;
  - non-load writing r5, ID reads r5 -> no stall.
- Multiply with MUL_LATENCY = 4: ex_busy is high for 3 consecutive cycles, starting the cycle after entry. During busy, PCWrite = 0 and RegWrite_EX_MEM = 0 (bubbles). The multiply's rd appears on rd_EX_MEM one cycle after busy drops.
- Branch vs load-use: branch_taken_EX = 1 while a load-use condition is present -> flush_IF_ID = 1, bubble_ID_EX = 1, PCWrite = 1.
- Branch during busy: branch_taken_EX = 1 in MUL_BUSY -> flush_IF_ID = 0, busy sequence unchanged.

Source files
------------

// File: rtl/hazard_stall_unit_pkg.sv
// Shared definitions for the hazard/stall unit: destination-tag layout,
// FSM state encoding and the hard-wired zero register index.
package hazard_stall_unit_pkg;

  localparam int REG_ADDR_W = 5;

  // Register index that is hard-wired to zero and never creates a hazard
  localparam logic [REG_ADDR_W-1:0] ZERO_REG = '0;

  // Destination tag carried alongside every in-flight instruction
  typedef struct packed {
    logic                  valid;
    logic [REG_ADDR_W-1:0] rd;
    logic                  regwrite;
    logic                  memread;
  } tag_t;

  localparam tag_t TAG_NONE = '0;

  typedef enum logic {
    IDLE     = 1'b0,
    MUL_BUSY = 1'b1
  } state_t;

endpackage

// File: rtl/hazard_tag_stage.sv
// One pipeline-register slot holding a destination tag. Hold keeps the
// current tag, bubble inserts an empty tag, load captures the incoming tag.
module hazard_tag_stage
  import hazard_stall_unit_pkg::*;
(
  input  logic clk,
  input  logic rst,
  input  logic load,
  input  logic hold,
  input  logic bubble,
  input  tag_t d,
  output tag_t q
);

  // Tag register: hold wins over bubble, bubble wins over load
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      q <= TAG_NONE;
    end else if (!hold) begin
      if (bubble) begin
        q <= TAG_NONE;
      end else if (load) begin
        q <= d;
      end
    end
  end

endmodule

// File: rtl/hazard_stall_unit.sv
// Tracks destination tags through EX, MEM and WB, publishes the EX/MEM and
// MEM/WB tags for the forwarding logic, and raises stall, bubble and flush
// controls for load-use hazards, multi-cycle multiplies and taken branches.
module hazard_stall_unit #(
  parameter int REG_ADDR_W  = 5,
  parameter int MUL_LATENCY = 4
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  id_valid,
  input  logic [REG_ADDR_W-1:0] rs1_IF_ID,
  input  logic [REG_ADDR_W-1:0] rs2_IF_ID,
  input  logic                  id_uses_rs2,
  input  logic [REG_ADDR_W-1:0] id_rd,
  input  logic                  id_RegWrite,
  input  logic                  id_MemRead,
  input  logic                  id_is_mul,
  input  logic                  branch_taken_EX,
  output logic                  PCWrite,
  output logic                  IF_ID_Write,
  output logic                  bubble_ID_EX,
  output logic                  flush_IF_ID,
  output logic                  ex_busy,
  output logic [REG_ADDR_W-1:0] rd_EX_MEM,
  output logic                  RegWrite_EX_MEM,
  output logic [REG_ADDR_W-1:0] rd_MEM_WB,
  output logic                  RegWrite_MEM_WB
);

  import hazard_stall_unit_pkg::*;

  // Counter is loaded with MUL_LATENCY-1, so 4 bits covers the legal range 2..15
  localparam logic [3:0] MUL_LOAD = 4'(MUL_LATENCY - 1);

  state_t     state;
  state_t     state_next;
  logic [3:0] mul_cnt;
  logic [3:0] mul_cnt_next;

  tag_t id_tag;
  tag_t ex_tag;
  tag_t mem_tag;
  tag_t wb_tag;

  logic busy;
  logic rs1_hit;
  logic rs2_hit;
  logic load_use;
  logic flush;
  logic stall;
  logic id_advance;
  logic mul_start;
  logic unused_memread;

  assign id_tag = '{valid: id_valid, rd: id_rd, regwrite: id_RegWrite, memread: id_MemRead};

  assign busy = (state == MUL_BUSY);

  assign rs1_hit  = (ex_tag.rd == rs1_IF_ID);
  assign rs2_hit  = id_uses_rs2 && (ex_tag.rd == rs2_IF_ID);
  assign load_use = id_valid && ex_tag.valid && ex_tag.memread && ex_tag.regwrite &&
                    (ex_tag.rd != ZERO_REG) && (rs1_hit || rs2_hit);

  // Busy masks everything; a flush beats a load-use stall
  assign flush      = branch_taken_EX && !busy;
  assign stall      = load_use && !busy && !flush;
  assign id_advance = !busy && !flush && !stall;
  assign mul_start  = id_advance && id_valid && id_is_mul;

  hazard_tag_stage u_ex_stage (
    .clk    (clk),
    .rst    (rst),
    .load   (id_advance),
    .hold   (busy),
    .bubble (flush || stall),
    .d      (id_tag),
    .q      (ex_tag)
  );

  hazard_tag_stage u_mem_stage (
    .clk    (clk),
    .rst    (rst),
    .load   (1'b1),
    .hold   (1'b0),
    .bubble (busy),
    .d      (ex_tag),
    .q      (mem_tag)
  );

  hazard_tag_stage u_wb_stage (
    .clk    (clk),
    .rst    (rst),
    .load   (1'b1),
    .hold   (1'b0),
    .bubble (1'b0),
    .d      (mem_tag),
    .q      (wb_tag)
  );

  // Multiply-occupancy state and remaining-cycle counter
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state   <= IDLE;
      mul_cnt <= '0;
    end else begin
      state   <= state_next;
      mul_cnt <= mul_cnt_next;
    end
  end

  // Next state plus front-end controls; busy outputs override flush and stall
  always_comb begin
    state_next   = state;
    mul_cnt_next = mul_cnt;
    PCWrite      = 1'b1;
    IF_ID_Write  = 1'b1;
    bubble_ID_EX = 1'b0;
    flush_IF_ID  = 1'b0;
    unique case (state)
      IDLE: begin
        if (flush) begin
          flush_IF_ID  = 1'b1;
          bubble_ID_EX = 1'b1;
        end else if (stall) begin
          PCWrite      = 1'b0;
          IF_ID_Write  = 1'b0;
          bubble_ID_EX = 1'b1;
        end
        if (mul_start) begin
          state_next   = MUL_BUSY;
          mul_cnt_next = MUL_LOAD;
        end
      end
      MUL_BUSY: begin
        PCWrite      = 1'b0;
        IF_ID_Write  = 1'b0;
        mul_cnt_next = mul_cnt - 4'd1;
        if (mul_cnt == 4'd1) begin
          state_next = IDLE;
        end
      end
      default: begin
        state_next   = IDLE;
        mul_cnt_next = '0;
      end
    endcase
  end

  assign ex_busy = busy;

  assign RegWrite_EX_MEM = mem_tag.valid && mem_tag.regwrite;
  assign rd_EX_MEM       = mem_tag.valid ? mem_tag.rd : ZERO_REG;
  assign RegWrite_MEM_WB = wb_tag.valid && wb_tag.regwrite;
  assign rd_MEM_WB       = wb_tag.valid ? wb_tag.rd : ZERO_REG;

  // The load flag is only needed while a tag sits in EX
  assign unused_memread = mem_tag.memread ^ wb_tag.memread;

endmodule

// File: tb/tb_hazard_stall_unit.sv
// Scoreboard bench: a stimulus process drives the DUT and pushes the expected
// response from a behavioural occupancy model; a monitor pops and compares.
module tb_hazard_stall_unit;

  localparam int REG_ADDR_W  = 5;
  localparam int MUL_LATENCY = 4;

  logic                  clk;
  logic                  rst;
  logic                  id_valid;
  logic [REG_ADDR_W-1:0] rs1_IF_ID;
  logic [REG_ADDR_W-1:0] rs2_IF_ID;
  logic                  id_uses_rs2;
  logic [REG_ADDR_W-1:0] id_rd;
  logic                  id_RegWrite;
  logic                  id_MemRead;
  logic                  id_is_mul;
  logic                  branch_taken_EX;
  logic                  PCWrite;
  logic                  IF_ID_Write;
  logic                  bubble_ID_EX;
  logic                  flush_IF_ID;
  logic                  ex_busy;
  logic [REG_ADDR_W-1:0] rd_EX_MEM;
  logic                  RegWrite_EX_MEM;
  logic [REG_ADDR_W-1:0] rd_MEM_WB;
  logic                  RegWrite_MEM_WB;

  hazard_stall_unit #(
    .REG_ADDR_W  (REG_ADDR_W),
    .MUL_LATENCY (MUL_LATENCY)
  ) dut (
    .clk             (clk),
    .rst             (rst),
    .id_valid        (id_valid),
    .rs1_IF_ID       (rs1_IF_ID),
    .rs2_IF_ID       (rs2_IF_ID),
    .id_uses_rs2     (id_uses_rs2),
    .id_rd           (id_rd),
    .id_RegWrite     (id_RegWrite),
    .id_MemRead      (id_MemRead),
    .id_is_mul       (id_is_mul),
    .branch_taken_EX (branch_taken_EX),
    .PCWrite         (PCWrite),
    .IF_ID_Write     (IF_ID_Write),
    .bubble_ID_EX    (bubble_ID_EX),
    .flush_IF_ID     (flush_IF_ID),
    .ex_busy         (ex_busy),
    .rd_EX_MEM       (rd_EX_MEM),
    .RegWrite_EX_MEM (RegWrite_EX_MEM),
    .rd_MEM_WB       (rd_MEM_WB),
    .RegWrite_MEM_WB (RegWrite_MEM_WB)
  );

  typedef struct {
    bit valid;
    int rd;
    bit rw;
    bit mr;
  } mtag_t;

  typedef struct {
    bit pc_write;
    bit ifid_write;
    bit bubble;
    bit flush;
    bit busy;
    int rd_em;
    bit rw_em;
    int rd_mw;
    bit rw_mw;
  } exp_t;

  localparam mtag_t NO_TAG = '{valid: 1'b0, rd: 0, rw: 1'b0, mr: 1'b0};

  exp_t  exp_q[$];
  mtag_t m_ex;
  mtag_t m_mem;
  mtag_t m_wb;
  int    mul_left;
  int    n_compared;
  int    n_mismatched;

  // Free-running pipeline clock
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic checkOutput(input string name, input int actual, input int expected);
    n_compared++;
    if (actual != expected) begin
      n_mismatched++;
      $display("[TB] FAIL %s at %0t: got %0d, expected %0d", name, $time, actual, expected);
    end
  endtask

  // Drive one cycle of inputs, push the expected outputs, then advance the model
  task automatic applyStimulus(input bit r, input bit v, input int rs1, input int rs2,
                               input bit u2, input int rd, input bit rw, input bit mr,
                               input bit mul, input bit br);
    exp_t e;
    bit   busy;
    bit   hz;
    rst             = r;
    id_valid        = v;
    rs1_IF_ID       = 5'(rs1);
    rs2_IF_ID       = 5'(rs2);
    id_uses_rs2     = u2;
    id_rd           = 5'(rd);
    id_RegWrite     = rw;
    id_MemRead      = mr;
    id_is_mul       = mul;
    branch_taken_EX = br;
    if (r) begin
      m_ex     = NO_TAG;
      m_mem    = NO_TAG;
      m_wb     = NO_TAG;
      mul_left = 0;
    end
    busy = (mul_left > 0);
    hz   = v && m_ex.valid && m_ex.mr && m_ex.rw && (m_ex.rd != 0) &&
           ((m_ex.rd == rs1) || (u2 && (m_ex.rd == rs2)));
    e.pc_write   = 1'b1;
    e.ifid_write = 1'b1;
    e.bubble     = 1'b0;
    e.flush      = 1'b0;
    if (busy) begin
      e.pc_write   = 1'b0;
      e.ifid_write = 1'b0;
    end else if (br) begin
      e.flush  = 1'b1;
      e.bubble = 1'b1;
    end else if (hz) begin
      e.pc_write   = 1'b0;
      e.ifid_write = 1'b0;
      e.bubble     = 1'b1;
    end
    e.busy  = busy;
    e.rw_em = m_mem.valid && m_mem.rw;
    e.rd_em = m_mem.valid ? m_mem.rd : 0;
    e.rw_mw = m_wb.valid && m_wb.rw;
    e.rd_mw = m_wb.valid ? m_wb.rd : 0;
    exp_q.push_back(e);
    @(posedge clk);
    if (!r) begin
      m_wb = m_mem;
      if (busy) begin
        m_mem    = NO_TAG;
        mul_left = mul_left - 1;
      end else begin
        m_mem = m_ex;
        if (br || hz) begin
          m_ex = NO_TAG;
        end else begin
          m_ex = '{valid: v, rd: rd, rw: rw, mr: mr};
          if (v && mul) mul_left = MUL_LATENCY - 1;
        end
      end
    end
    #1;
  endtask

  task automatic idle_cycle();
    applyStimulus(1'b0, 1'b0, 0, 0, 1'b0, 0, 1'b0, 1'b0, 1'b0, 1'b0);
  endtask

  // Monitor: one expected entry per cycle, compared mid-cycle
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      if (exp_q.size() > 0) begin
        e = exp_q.pop_front();
        checkOutput("PCWrite",         int'(PCWrite),         int'(e.pc_write));
        checkOutput("IF_ID_Write",     int'(IF_ID_Write),     int'(e.ifid_write));
        checkOutput("bubble_ID_EX",    int'(bubble_ID_EX),    int'(e.bubble));
        checkOutput("flush_IF_ID",     int'(flush_IF_ID),     int'(e.flush));
        checkOutput("ex_busy",         int'(ex_busy),         int'(e.busy));
        checkOutput("rd_EX_MEM",       int'(rd_EX_MEM),       e.rd_em);
        checkOutput("RegWrite_EX_MEM", int'(RegWrite_EX_MEM), int'(e.rw_em));
        checkOutput("rd_MEM_WB",       int'(rd_MEM_WB),       e.rd_mw);
        checkOutput("RegWrite_MEM_WB", int'(RegWrite_MEM_WB), int'(e.rw_mw));
      end
    end
  end

  // Stimulus: directed scenarios followed by randomized traffic
  initial begin
    n_compared   = 0;
    n_mismatched = 0;
    m_ex         = NO_TAG;
    m_mem        = NO_TAG;
    m_wb         = NO_TAG;
    mul_left     = 0;
    rst             = 1'b1;
    id_valid        = 1'b0;
    rs1_IF_ID       = '0;
    rs2_IF_ID       = '0;
    id_uses_rs2     = 1'b0;
    id_rd           = '0;
    id_RegWrite     = 1'b0;
    id_MemRead      = 1'b0;
    id_is_mul       = 1'b0;
    branch_taken_EX = 1'b0;
    @(posedge clk);
    #1;

    applyStimulus(1'b1, 1'b0, 0, 0, 1'b0, 0, 1'b0, 1'b0, 1'b0, 1'b0);
    applyStimulus(1'b1, 1'b0, 0, 0, 1'b0, 0, 1'b0, 1'b0, 1'b0, 1'b0);
    idle_cycle();

    // load r5 followed by a reader of r5: one stall, then forwarding of r5
    applyStimulus(1'b0, 1'b1, 1, 2, 1'b1, 5, 1'b1, 1'b1, 1'b0, 1'b0);
    applyStimulus(1'b0, 1'b1, 5, 3, 1'b0, 6, 1'b1, 1'b0, 1'b0, 1'b0);
    applyStimulus(1'b0, 1'b1, 5, 3, 1'b0, 6, 1'b1, 1'b0, 1'b0, 1'b0);
    idle_cycle();
    idle_cycle();

    // load to r0 never stalls
    applyStimulus(1'b0, 1'b1, 1, 2, 1'b0, 0, 1'b1, 1'b1, 1'b0, 1'b0);
    applyStimulus(1'b0, 1'b1, 0, 0, 1'b1, 4, 1'b1, 1'b0, 1'b0, 1'b0);

    // rs2 match is ignored when rs2 is not read
    applyStimulus(1'b0, 1'b1, 1, 2, 1'b0, 7, 1'b1, 1'b1, 1'b0, 1'b0);
    applyStimulus(1'b0, 1'b1, 3, 7, 1'b0, 4, 1'b1, 1'b0, 1'b0, 1'b0);

    // non-load producer is covered by forwarding
    applyStimulus(1'b0, 1'b1, 1, 2, 1'b0, 5, 1'b1, 1'b0, 1'b0, 1'b0);
    applyStimulus(1'b0, 1'b1, 5, 5, 1'b1, 4, 1'b1, 1'b0, 1'b0, 1'b0);
    idle_cycle();
    idle_cycle();

    // multiply to r9: three busy cycles, then r9 on the EX/MEM interface
    applyStimulus(1'b0, 1'b1, 1, 2, 1'b1, 9, 1'b1, 1'b0, 1'b1, 1'b0);
    for (int i = 0; i < 6; i++) begin
      applyStimulus(1'b0, 1'b1, 3, 4, 1'b1, 10, 1'b1, 1'b0, 1'b0, 1'b0);
    end
    idle_cycle();

    // branch taken while a load-use condition is present
    applyStimulus(1'b0, 1'b1, 1, 2, 1'b0, 5, 1'b1, 1'b1, 1'b0, 1'b0);
    applyStimulus(1'b0, 1'b1, 5, 0, 1'b0, 6, 1'b1, 1'b0, 1'b0, 1'b1);
    idle_cycle();

    // branch taken during busy is ignored
    applyStimulus(1'b0, 1'b1, 1, 2, 1'b1, 11, 1'b1, 1'b0, 1'b1, 1'b0);
    applyStimulus(1'b0, 1'b1, 3, 4, 1'b1, 12, 1'b1, 1'b0, 1'b0, 1'b1);
    applyStimulus(1'b0, 1'b1, 3, 4, 1'b1, 12, 1'b1, 1'b0, 1'b0, 1'b1);
    for (int i = 0; i < 4; i++) idle_cycle();

    // reset while the multiply counter is at 2
    applyStimulus(1'b0, 1'b1, 1, 2, 1'b1, 13, 1'b1, 1'b0, 1'b1, 1'b0);
    idle_cycle();
    applyStimulus(1'b1, 1'b0, 0, 0, 1'b0, 0, 1'b0, 1'b0, 1'b0, 1'b0);
    applyStimulus(1'b1, 1'b0, 0, 0, 1'b0, 0, 1'b0, 1'b0, 1'b0, 1'b0);
    idle_cycle();
    applyStimulus(1'b0, 1'b1, 1, 2, 1'b1, 14, 1'b1, 1'b0, 1'b1, 1'b0);
    for (int i = 0; i < 5; i++) idle_cycle();

    // randomized traffic over a small register range to provoke hazards
    for (int i = 0; i < 600; i++) begin
      bit r;
      bit mr;
      r  = ($urandom_range(0, 99) < 2);
      mr = ($urandom_range(0, 99) < 35);
      applyStimulus(r,
                    $urandom_range(0, 99) < 90,
                    int'($urandom_range(0, 7)),
                    int'($urandom_range(0, 7)),
                    $urandom_range(0, 1) == 1,
                    int'($urandom_range(0, 7)),
                    $urandom_range(0, 99) < 85,
                    mr,
                    !mr && ($urandom_range(0, 99) < 10),
                    $urandom_range(0, 99) < 10);
    end
    idle_cycle();

    for (int i = 0; i < 5 && exp_q.size() > 0; i++) @(negedge clk);
    checkOutput("queue_drained", exp_q.size(), 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_compared, n_mismatched);
    $finish;
  end

endmodule
